// File: rtl/data_mem_ctrl_pkg.sv
// Shared types for the data-memory controller: FSM state encoding and
// default widths used by data_mem_ctrl.
package data_mem_ctrl_pkg;

    localparam int DEF_WORD_W   = 32;
    localparam int DEF_ADDR_LSB = 2;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } state_e;

endpackage

// File: rtl/data_mem_ctrl.sv
// Multi-cycle data-memory controller below the memory-access stage.
// Turns a single-cycle load/store into a valid/ready request plus a
// response handshake and stalls the pipeline while the access is in flight.
// Ports: clk, rst (async, active-high); re_m/we_m/addr_m/din_m from the
// memory stage; dout/stall_mem back to it; mem_req_* request channel and
// mem_resp_* response channel toward the memory.
module data_mem_ctrl
    import data_mem_ctrl_pkg::*;
#(
    parameter int ADDR_LSB = DEF_ADDR_LSB,
    parameter int WORD_W   = DEF_WORD_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 re_m,
    input  logic                 we_m,
    input  logic [31:0]          addr_m,
    input  logic [WORD_W-1:0]    din_m,
    output logic [WORD_W-1:0]    dout,
    output logic                 stall_mem,
    output logic                 mem_req_valid,
    input  logic                 mem_req_ready,
    output logic                 mem_req_we,
    output logic [31-ADDR_LSB:0] mem_req_addr,
    output logic [WORD_W-1:0]    mem_req_wdata,
    input  logic                 mem_resp_valid,
    input  logic [WORD_W-1:0]    mem_resp_data
);

    state_e                state_q, state_d;
    logic [WORD_W-1:0]     dout_q, dout_d;
    logic                  req_we_q, req_we_d;
    logic [31-ADDR_LSB:0]  req_addr_q, req_addr_d;
    logic [WORD_W-1:0]     req_wdata_q, req_wdata_d;

    logic access;
    logic unused_addr_lsb;

    // A store wins when both strobes are set.
    assign access          = re_m | we_m;
    assign unused_addr_lsb = ^addr_m[ADDR_LSB-1:0];

    // DONE releases the stall so the pipeline advances on this edge.
    assign stall_mem = access & (state_q != DONE);
    assign dout      = dout_q;

    always_comb begin
        state_d       = state_q;
        dout_d        = dout_q;
        req_we_d      = req_we_q;
        req_addr_d    = req_addr_q;
        req_wdata_d   = req_wdata_q;
        mem_req_valid = 1'b0;
        mem_req_we    = 1'b0;
        mem_req_addr  = '0;
        mem_req_wdata = '0;
        unique case (state_q)
            IDLE: begin
                if (access) begin
                    mem_req_valid = 1'b1;
                    mem_req_we    = we_m;
                    mem_req_addr  = addr_m[31:ADDR_LSB];
                    mem_req_wdata = din_m;
                    // Hold the request stable if it is not taken now.
                    req_we_d      = we_m;
                    req_addr_d    = addr_m[31:ADDR_LSB];
                    req_wdata_d   = din_m;
                    if (!mem_req_ready) begin
                        state_d = REQ;
                    end else if (we_m) begin
                        state_d = DONE;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            REQ: begin
                mem_req_valid = 1'b1;
                mem_req_we    = req_we_q;
                mem_req_addr  = req_addr_q;
                mem_req_wdata = req_wdata_q;
                if (mem_req_ready) begin
                    state_d = req_we_q ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (mem_resp_valid) begin
                    dout_d  = mem_resp_data;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            dout_q      <= '0;
            req_we_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            dout_q      <= dout_d;
            req_we_q    <= req_we_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: directed scenarios plus random
// load/store traffic against a transaction-level memory model.
module tb_data_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        re_m;
    logic        we_m;
    logic [31:0] addr_m;
    logic [31:0] din_m;
    logic [31:0] dout;
    logic        stall_mem;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_we;
    logic [29:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] mem [logic [29:0]];
    logic [31:0] exp_dout = '0;

    data_mem_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .re_m          (re_m),
        .we_m          (we_m),
        .addr_m        (addr_m),
        .din_m         (din_m),
        .dout          (dout),
        .stall_mem     (stall_mem),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_we    (mem_req_we),
        .mem_req_addr  (mem_req_addr),
        .mem_req_wdata (mem_req_wdata),
        .mem_resp_valid(mem_resp_valid),
        .mem_resp_data (mem_resp_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One access as seen by the memory stage. The bench plays the memory:
    // ready rises after dly cycles, read data returns lat cycles after
    // acceptance. Expected stall length: dly+1 for a store, dly+1+lat for
    // a load, followed by one unstalled cycle.
    task automatic do_op(input bit rd, input bit wr,
                         input logic [31:0] a, input logic [31:0] d,
                         input int dly, input int lat);
        bit          is_wr  = wr;
        bit          acc    = 1'b0;
        bit          fin    = 1'b0;
        int          since  = 0;
        int          cyc    = 0;
        int          stalls = 0;
        int          reqs   = 0;
        int          exp_st;
        logic [31:0] rdata  = '0;
        logic [31:0] old_dout;
        exp_st   = is_wr ? dly + 1 : dly + 1 + lat;
        old_dout = exp_dout;
        if (!is_wr) begin
            if (!mem.exists(a[31:2])) mem[a[31:2]] = $urandom;
            rdata = mem[a[31:2]];
        end
        re_m   = rd;
        we_m   = wr;
        addr_m = a;
        din_m  = d;
        while (!fin && cyc < 200) begin
            mem_resp_valid = 1'b0;
            mem_resp_data  = $urandom;
            if (acc) begin
                mem_req_ready = 1'b1;
                if (!is_wr && since == lat) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_data  = rdata;
                end
            end else begin
                mem_req_ready = (cyc >= dly);
                // Stray responses before acceptance must be ignored.
                mem_resp_valid = ($urandom_range(0, 3) == 0);
                // Request must come from the held copy, not live inputs.
                if (cyc > 0) begin
                    addr_m = $urandom;
                    din_m  = $urandom;
                end
            end
            @(negedge clk);
            if (mem_req_valid) begin
                chk("req_we", {31'b0, mem_req_we}, {31'b0, is_wr});
                chk("req_addr", {2'b0, mem_req_addr}, {2'b0, a[31:2]});
                if (is_wr) chk("req_wdata", mem_req_wdata, d);
            end
            if (mem_req_valid && mem_req_ready) reqs++;
            if (!stall_mem) begin
                fin = 1'b1;
                if (is_wr) mem[a[31:2]] = d;
                else exp_dout = rdata;
                chk("stall_cycles", stalls, exp_st);
                chk("n_req", reqs, 1);
                chk("done_valid", {31'b0, mem_req_valid}, 32'd0);
                chk("done_dout", dout, exp_dout);
            end else begin
                stalls++;
                chk("req_valid", {31'b0, mem_req_valid}, {31'b0, !acc});
                chk("dout_hold", dout, old_dout);
                if (!acc && mem_req_valid && mem_req_ready) begin
                    acc   = 1'b1;
                    since = 0;
                end
            end
            @(posedge clk);
            #1;
            cyc++;
            if (acc) since++;
        end
        if (!fin) chk("timeout", 32'd1, 32'd0);
        mem_resp_valid = 1'b0;
        mem_req_ready  = 1'b0;
    endtask

    task automatic idle(input int n);
        re_m = 1'b0;
        we_m = 1'b0;
        for (int i = 0; i < n; i++) begin
            mem_req_ready  = $urandom_range(0, 1);
            mem_resp_valid = 1'b0;
            @(negedge clk);
            chk("idle_stall", {31'b0, stall_mem}, 32'd0);
            chk("idle_valid", {31'b0, mem_req_valid}, 32'd0);
            chk("idle_dout", dout, exp_dout);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst            = 1'b1;
        re_m           = 1'b0;
        we_m           = 1'b0;
        addr_m         = '0;
        din_m          = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        #2;
        chk("rst_dout", dout, 32'd0);
        chk("rst_stall", {31'b0, stall_mem}, 32'd0);
        chk("rst_valid", {31'b0, mem_req_valid}, 32'd0);
        chk("rst_addr", {2'b0, mem_req_addr}, 32'd0);
        chk("rst_wdata", mem_req_wdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed scenarios.
        do_op(1'b0, 1'b1, 32'h0000_0104, 32'hDEAD_BEEF, 0, 1);
        idle(1);
        mem[30'h80] = 32'h1234_5678;
        do_op(1'b1, 1'b0, 32'h0000_0200, 32'h0, 0, 3);
        idle(1);
        do_op(1'b0, 1'b1, 32'h0000_0044, 32'hCAFE_F00D, 5, 1);
        mem[30'h4] = 32'hAAAA_0001;
        mem[30'h5] = 32'hBBBB_0002;
        do_op(1'b1, 1'b0, 32'h0000_0010, 32'h0, 0, 1);
        do_op(1'b1, 1'b0, 32'h0000_0014, 32'h0, 0, 1);
        do_op(1'b1, 1'b1, 32'h0000_0020, 32'h5555_AAAA, 0, 1);
        do_op(1'b1, 1'b0, 32'h0000_0020, 32'h0, 1, 2);

        // Async reset while waiting for a load response.
        re_m          = 1'b1;
        we_m          = 1'b0;
        addr_m        = 32'h0000_0300;
        mem_req_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        mem_req_ready = 1'b0;
        @(negedge clk);
        chk("wait_stall", {31'b0, stall_mem}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_stall", {31'b0, stall_mem}, 32'd1);
        chk("arst_dout", dout, 32'd0);
        re_m = 1'b0;
        #1;
        chk("arst_noacc", {31'b0, stall_mem}, 32'd0);
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'hBAD0_BAD0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        mem_resp_valid = 1'b0;
        chk("late_resp", dout, 32'd0);
        chk("late_valid", {31'b0, mem_req_valid}, 32'd0);
        exp_dout = '0;

        // Random traffic.
        for (int k = 0; k < 150; k++) begin
            int          kind;
            logic [31:0] a;
            kind = $urandom_range(0, 9);
            a    = {26'b0, 4'($urandom_range(0, 15)), 2'($urandom)};
            if (kind == 0)
                do_op(1'b1, 1'b1, a, $urandom, $urandom_range(0, 3),
                      $urandom_range(1, 4));
            else if (kind < 5)
                do_op(1'b0, 1'b1, a, $urandom, $urandom_range(0, 3),
                      $urandom_range(1, 4));
            else
                do_op(1'b1, 1'b0, a, $urandom, $urandom_range(0, 3),
                      $urandom_range(1, 4));
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
